// File: rtl/button_event_pkg.sv
// Shared types and constants for the button event arbiter.
package button_event_pkg;

  localparam int OVF_W = 8;

  typedef enum logic {
    ST_EMPTY   = 1'b0,
    ST_PRESENT = 1'b1
  } state_e;

  // Index width for n requesters, never narrower than one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_event_arbiter_rr_priority_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping at width-1.
module rr_priority_pick
  import button_event_pkg::*;
#(
  parameter int width = 4,
  localparam int ID_W = id_w(width)
) (
  input  logic [width-1:0] req,
  input  logic [ID_W-1:0]  start,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_idx
);

  // Scan from the farthest offset down so the nearest request to start wins last.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int off = width - 1; off >= 0; off--) begin
      int idx;
      idx = (int'(start) + off) % width;
      if (req[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Serialises single-cycle button pulses into a valid/ready event stream (round robin).
// Optional: define BUTTON_EVENT_OVERFLOW_CNT_EN to add the saturating dropped-pulse counter.
module button_event_arbiter
  import button_event_pkg::*;
#(
  parameter int width = 4,
  localparam int ID_W = id_w(width)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width-1:0] edge_pulse,
  output logic             event_valid,
  input  logic             event_ready,
  output logic [ID_W-1:0]  event_id,
  output logic [width-1:0] pending
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
  ,
  output logic [OVF_W-1:0] overflow_count
`endif
);

  state_e            state;
  logic [ID_W-1:0]   rr_ptr;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic              load;
  logic [width-1:0]  load_mask;
  logic [width-1:0]  pending_next;

  rr_priority_pick #(.width(width)) u_pick (
    .req         (pending),
    .start       (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // A pulse on the bit being loaded re-arms it, since the clear and the set share one edge.
  always_comb begin
    load      = grant_valid && ((state == ST_EMPTY) || event_ready);
    load_mask = '0;
    if (load) load_mask[grant_idx] = 1'b1;
    pending_next = (pending & ~load_mask) | edge_pulse;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state       <= ST_EMPTY;
      event_valid <= 1'b0;
      event_id    <= '0;
      rr_ptr      <= '0;
      pending     <= '0;
    end else begin
      pending <= pending_next;
      if (load) begin
        state       <= ST_PRESENT;
        event_valid <= 1'b1;
        event_id    <= grant_idx;
        rr_ptr      <= (grant_idx == ID_W'(width - 1)) ? '0 : grant_idx + 1'b1;
      end else if ((state == ST_PRESENT) && event_ready) begin
        state       <= ST_EMPTY;
        event_valid <= 1'b0;
      end
    end
  end

`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
  logic [width-1:0] drop_mask;
  logic [OVF_W:0]   drop_cnt;
  logic [OVF_W:0]   ovf_sum;

  // A drop is a pulse landing on a bit that is still pending and not being loaded.
  always_comb begin
    drop_mask = edge_pulse & pending & ~load_mask;
    drop_cnt  = '0;
    for (int i = 0; i < width; i++) drop_cnt += (OVF_W + 1)'(drop_mask[i]);
    ovf_sum = {1'b0, overflow_count} + drop_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          overflow_count <= '0;
    else if (ovf_sum[OVF_W]) overflow_count <= '1;
    else                 overflow_count <= ovf_sum[OVF_W-1:0];
  end
`endif

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed self-checking bench for button_event_arbiter (width=4), with or without the overflow counter.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] edge_pulse;
  logic       event_ready;
  logic       event_valid;
  logic [1:0] event_id;
  logic [3:0] pending;
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
  logic [7:0] overflow_count;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  button_event_arbiter #(.width(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .edge_pulse  (edge_pulse),
    .event_valid (event_valid),
    .event_ready (event_ready),
    .event_id    (event_id),
    .pending     (pending)
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
    ,
    .overflow_count (overflow_count)
`endif
  );

  // Advance one edge; outputs are read 1 time unit later, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; edge_pulse = '0; event_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; edge_pulse = 4'b1111; event_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (event_valid !== 1'b0 || pending !== 4'b0000) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: valid=%b pending=%b want valid=0 pending=0000", c, event_valid, pending);
      end
    end
    n_cmp++;
    if (event_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_id: got %0d want 0", event_id);
    end
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
    n_cmp++;
    if (overflow_count !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %0d want 0", overflow_count);
    end
`endif
    rst_n = 1'b1; edge_pulse = '0;
    tick();
    n_cmp++;
    if (event_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b pending=%b want valid=0 pending=0000", event_valid, pending);
    end
  endtask

  task automatic test_single();
    do_reset();
    event_ready = 1'b1; edge_pulse = 4'b0100;
    tick();
    edge_pulse = '0;
    n_cmp++;
    if (event_valid !== 1'b0 || pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL single_pend: valid=%b pending=%b want valid=0 pending=0100", event_valid, pending);
    end
    tick();
    n_cmp++;
    if (event_valid !== 1'b1 || event_id !== 2'd2 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_present: valid=%b id=%0d pending=%b want 1/2/0000", event_valid, event_id, pending);
    end
    tick();
    n_cmp++;
    if (event_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_done: valid=%b pending=%b want 0/0000", event_valid, pending);
    end
  endtask

  // Pulse a mask once with ready high, then expect ids in order followed by an idle cycle.
  task automatic burst(input string name, input logic [3:0] mask, input int n_ids,
                       input logic [1:0] ids [4], input logic [3:0] pends [4]);
    edge_pulse = mask;
    tick();
    edge_pulse = '0;
    for (int e = 0; e < n_ids; e++) begin
      tick();
      n_cmp++;
      if (event_valid !== 1'b1 || event_id !== ids[e] || pending !== pends[e]) begin
        n_fail++;
        $display("FAIL %s ev%0d: valid=%b id=%0d pending=%b want 1/%0d/%b",
                 name, e, event_valid, event_id, pending, ids[e], pends[e]);
      end
    end
    tick();
    n_cmp++;
    if (event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle: valid=%b want 0", name, event_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [1:0] ids [4];
    logic [3:0] pends [4];
    do_reset();
    event_ready = 1'b1;
    ids = '{2'd0, 2'd1, 2'd3, 2'd0};
    pends = '{4'b1010, 4'b1000, 4'b0000, 4'b0000};
    burst("simul_1011", 4'b1011, 3, ids, pends);
    ids = '{2'd0, 2'd3, 2'd0, 2'd0};
    pends = '{4'b1000, 4'b0000, 4'b0000, 4'b0000};
    burst("simul_1001", 4'b1001, 2, ids, pends);
  endtask

  // After granting 1 the search starts at 2, so 0111 comes out as 2,0,1.
  task automatic test_rr_fairness();
    logic [1:0] ids [4];
    logic [3:0] pends [4];
    do_reset();
    event_ready = 1'b1;
    ids = '{2'd1, 2'd0, 2'd0, 2'd0};
    pends = '{4'b0000, 4'b0000, 4'b0000, 4'b0000};
    burst("rr_prime", 4'b0010, 1, ids, pends);
    ids = '{2'd2, 2'd0, 2'd1, 2'd0};
    pends = '{4'b0011, 4'b0010, 4'b0000, 4'b0000};
    burst("rr_0111", 4'b0111, 3, ids, pends);
  endtask

  task automatic test_backpressure();
    do_reset();
    event_ready = 1'b0; edge_pulse = 4'b0010;
    tick();
    edge_pulse = '0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if (event_valid !== 1'b1 || event_id !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: valid=%b id=%0d want 1/1", c, event_valid, event_id);
      end
    end
    event_ready = 1'b1;
    tick();
    n_cmp++;
    if (event_valid !== 1'b0 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL bp_accept: valid=%b pending=%b want 0/0000", event_valid, pending);
    end
    event_ready = 1'b0;
  endtask

  task automatic test_drop();
    int delivered;
    do_reset();
    event_ready = 1'b0;
    for (int p = 0; p < 3; p++) begin
      edge_pulse = 4'b0001;
      tick();
      edge_pulse = '0;
      tick();
    end
    n_cmp++;
    if (event_valid !== 1'b1 || event_id !== 2'd0 || pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL drop_state: valid=%b id=%0d pending=%b want 1/0/0001", event_valid, event_id, pending);
    end
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
    n_cmp++;
    if (overflow_count !== 8'd1) begin
      n_fail++;
      $display("FAIL drop_ovf: got %0d want 1", overflow_count);
    end
`endif
    delivered = 0;
    event_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (event_valid === 1'b1 && event_id === 2'd0) delivered++;
      tick();
    end
    n_cmp++;
    if (delivered != 2) begin
      n_fail++;
      $display("FAIL drop_count: delivered %0d want 2", delivered);
    end
    event_ready = 1'b0;
  endtask

  task automatic test_reload_race();
    do_reset();
    event_ready = 1'b1; edge_pulse = 4'b1000;
    tick();
    tick();
    edge_pulse = '0;
    n_cmp++;
    if (event_valid !== 1'b1 || event_id !== 2'd3 || pending !== 4'b1000) begin
      n_fail++;
      $display("FAIL race_rearm: valid=%b id=%0d pending=%b want 1/3/1000", event_valid, event_id, pending);
    end
    tick();
    n_cmp++;
    if (event_valid !== 1'b1 || event_id !== 2'd3 || pending !== 4'b0000) begin
      n_fail++;
      $display("FAIL race_second: valid=%b id=%0d pending=%b want 1/3/0000", event_valid, event_id, pending);
    end
    tick();
    n_cmp++;
    if (event_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL race_idle: valid=%b want 0", event_valid);
    end
`ifdef BUTTON_EVENT_OVERFLOW_CNT_EN
    n_cmp++;
    if (overflow_count !== 8'd0) begin
      n_fail++;
      $display("FAIL race_ovf: got %0d want 0", overflow_count);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; edge_pulse = '0; event_ready = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_rr_fairness();
    test_backpressure();
    test_drop();
    test_reload_race();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
